am_query_arbiter: RTL and testbench
===================================

AM_QUERY_ARBITER -- requirements
Module: am_query_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of encoder channels sharing one associative memory; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, watchdog limit in WAIT_RESULT (used only when AM_ARB_TIMEOUT_EN is defined); 8-bit counter.
REQ-003 Widths `HV_DIMENSION, `LABEL_WIDTH and `DISTANCE_WIDTH SHALL be taken from const.vh; ID_W = ceilLog2(NUM_REQ).
REQ-004 Clk_CI  in  1  single clock; all state changes on its rising edge.
REQ-005 Reset_RBI  in  1  asynchronous, active-low reset.
REQ-006 ReqValid_SI / ReqReady_SO  in / out  NUM_REQ  per-channel query handshake.
REQ-007 ReqHypervector_DI  in  NUM_REQ*`HV_DIMENSION  channel i occupies slice i.
REQ-008 AmValid_SO / AmReady_SI  out / in  1 / 1  query handshake toward the associative memory.
REQ-009 AmHypervector_DO  out  `HV_DIMENSION  registered query.
REQ-010 AmResValid_SI / AmResReady_SO  in / out  1 / 1  result handshake from the memory.
REQ-011 AmLabel_A_DI, AmLabel_V_DI  in  `LABEL_WIDTH each; AmDistance_A_DI, AmDistance_V_DI  in  `DISTANCE_WIDTH each.
REQ-012 RespValid_SO / RespReady_SI  out / in  NUM_REQ  per-channel result handshake.
REQ-013 RespLabel_A_DO, RespLabel_V_DO, RespDistance_A_DO, RespDistance_V_DO  out  registered result, shared by all channels.
REQ-014 RespId_DO  out  ID_W  index of the served channel; RespTimeout_SO  out  1  timeout flag.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT_RESULT and RESPOND, with exactly one query outstanding at a time.
REQ-016 IDLE: grant the first channel with ReqValid_SI set, searching round-robin from pointer RrPtr; ReqReady_SO SHALL be high only for the granted channel, combinationally.
REQ-017 On the IDLE handshake: latch the hypervector and grant ID, then go to ISSUE; with no valid requester, stay in IDLE.
REQ-018 ISSUE: AmValid_SO = 1 and AmHypervector_DO held stable until AmReady_SI; on the handshake go to WAIT_RESULT.
REQ-019 WAIT_RESULT: AmResReady_SO = 1; on AmResValid_SI, register labels and distances, clear RespTimeout_SO, go to RESPOND.
REQ-020 RESPOND: RespValid_SO[granted] = 1, all other bits 0, with data held stable; on RespReady_SI[granted], go to IDLE and set RrPtr = (granted + 1) mod NUM_REQ.
REQ-021 No new ReqReady_SO SHALL be asserted outside IDLE; requests arriving mid-transaction wait.
REQ-022 Minimum latency, with all partners always ready: request handshake at cycle 0, AmValid_SO at 1, result at 2, RespValid_SO at 3, next grant possible at 4.
REQ-023 Simultaneous requests SHALL be served in round-robin order; wrap from NUM_REQ-1 to 0.
REQ-024 A channel dropping ReqValid_SI before its handshake SHALL lose nothing; arbitration re-evaluates each IDLE cycle.
REQ-025 RespReady_SI on non-granted channels SHALL be ignored.

Reset
REQ-026 When Reset_RBI is low, regardless of state:
- state = IDLE, RrPtr = 0
- AmValid_SO = 0, AmResReady_SO = 0, RespValid_SO = 0
- all Resp* data = 0, RespTimeout_SO = 0, AmHypervector_DO = 0
REQ-027 Reset mid-transaction SHALL abandon the transaction; any late memory result is not captured, because AmResReady_SO = 0 in IDLE.

Configuration
REQ-028 With macro AM_ARB_TIMEOUT_EN defined:
- an 8-bit counter clears on entry to WAIT_RESULT and increments each cycle there
- on reaching TIMEOUT_CYCLES without a result, go to RESPOND with RespTimeout_SO = 1, labels = 0, distances = all ones
REQ-029 Without AM_ARB_TIMEOUT_EN: no counter is built, WAIT_RESULT waits indefinitely, and RespTimeout_SO is tied to 0.

Verification
REQ-030 Single request: ch1 valid with HV=0xA5.., all partners ready -> AmHypervector_DO=0xA5.. at cycle 1; RespValid_SO=3'b010 and RespId_DO=1 at cycle 3.
REQ-031 Contention: ch0, ch1 and ch2 held valid from reset -> grants in order 0,1,2,0; RrPtr wraps.
REQ-032 Backpressure: AmReady_SI low for 5 cycles, then RespReady_SI low for 3 cycles -> AmHypervector_DO and Resp* data are stable throughout; exactly one transfer each.
REQ-033 Reset asserted in WAIT_RESULT, with AmResValid_SI pulsed 2 cycles after release -> state IDLE, no RespValid_SO, pulse ignored.
REQ-034 Timeout (AM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10): no AmResValid_SI -> RespValid_SO 10 cycles after entering WAIT_RESULT, RespTimeout_SO=1, distances all ones; without the macro, still waiting after 1000 cycles.

Source files
------------

// File: rtl/am_query_arbiter.sv
// am_query_arbiter: shares one associative memory between NUM_REQ encoder
// channels. One query is in flight at a time; channels are served round-robin.
// Optional feature macro: AM_ARB_TIMEOUT_EN adds a WAIT_RESULT watchdog that
// answers with a timeout result after TIMEOUT_CYCLES cycles.
// Widths normally come from const.vh; the fallbacks below keep the file
// self-contained when that header has not been included first.

`ifndef HV_DIMENSION
`define HV_DIMENSION 32
`endif
`ifndef LABEL_WIDTH
`define LABEL_WIDTH 4
`endif
`ifndef DISTANCE_WIDTH
`define DISTANCE_WIDTH 8
`endif

// Per-channel handshake decode: request grant in IDLE, response select in RESPOND.
module am_query_arbiter_lane #(
  parameter int ID_W = 2,
  parameter int CH   = 0
) (
  input  logic [ID_W-1:0] grantId,
  input  logic            grantHit,
  input  logic [ID_W-1:0] servedId,
  input  logic            inIdle,
  input  logic            inRespond,
  output logic            reqReady,
  output logic            respValid
);
  localparam logic [ID_W-1:0] MyId = ID_W'(CH);

  assign reqReady  = inIdle & grantHit & (grantId == MyId);
  assign respValid = inRespond & (servedId == MyId);
endmodule

module am_query_arbiter #(
  parameter  int NUM_REQ        = 3,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              Clk_CI,
  input  logic                              Reset_RBI,
  input  logic [NUM_REQ-1:0]                ReqValid_SI,
  output logic [NUM_REQ-1:0]                ReqReady_SO,
  input  logic [NUM_REQ*`HV_DIMENSION-1:0]  ReqHypervector_DI,
  output logic                              AmValid_SO,
  input  logic                              AmReady_SI,
  output logic [`HV_DIMENSION-1:0]          AmHypervector_DO,
  input  logic                              AmResValid_SI,
  output logic                              AmResReady_SO,
  input  logic [`LABEL_WIDTH-1:0]           AmLabel_A_DI,
  input  logic [`LABEL_WIDTH-1:0]           AmLabel_V_DI,
  input  logic [`DISTANCE_WIDTH-1:0]        AmDistance_A_DI,
  input  logic [`DISTANCE_WIDTH-1:0]        AmDistance_V_DI,
  output logic [NUM_REQ-1:0]                RespValid_SO,
  input  logic [NUM_REQ-1:0]                RespReady_SI,
  output logic [`LABEL_WIDTH-1:0]           RespLabel_A_DO,
  output logic [`LABEL_WIDTH-1:0]           RespLabel_V_DO,
  output logic [`DISTANCE_WIDTH-1:0]        RespDistance_A_DO,
  output logic [`DISTANCE_WIDTH-1:0]        RespDistance_V_DO,
  output logic [ID_W-1:0]                   RespId_DO,
  output logic                              RespTimeout_SO
);

  localparam int HV_W   = `HV_DIMENSION;
  localparam int LBL_W  = `LABEL_WIDTH;
  localparam int DIST_W = `DISTANCE_WIDTH;

  // Elaboration-time range checks on the configuration.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : gBadNumReq
    $error("am_query_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
    $error("am_query_arbiter: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESULT, RESPOND} state_t;

  typedef struct packed {
    logic [LBL_W-1:0]  labelA;
    logic [LBL_W-1:0]  labelV;
    logic [DIST_W-1:0] distA;
    logic [DIST_W-1:0] distV;
  } amRes_t;

  state_t                      StateDP, StateDN;
  logic [ID_W-1:0]             RrPtrDP, RrPtrDN;
  logic [ID_W-1:0]             ServedIdDP, ServedIdDN;
  logic [HV_W-1:0]             HvDP, HvDN;
  amRes_t                      ResDP, ResDN;

  logic [NUM_REQ-1:0][HV_W-1:0] reqHv;
  logic [ID_W-1:0]             grantId;
  logic                        grantHit;
  int                          scanIdx;

  assign reqHv = ReqHypervector_DI;

`ifdef AM_ARB_TIMEOUT_EN
  localparam logic [7:0] TimerLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] TimerDP, TimerDN;
  logic       TimeoutDP, TimeoutDN;
`endif

  // Round-robin scan from RrPtr; walking offsets downward lets the nearest
  // valid channel overwrite any farther one.
  always_comb begin
    grantHit = 1'b0;
    grantId  = '0;
    scanIdx  = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scanIdx = (int'(RrPtrDP) + i) % NUM_REQ;
      if (ReqValid_SI[scanIdx]) begin
        grantHit = 1'b1;
        grantId  = ID_W'(scanIdx);
      end
    end
  end

  // Next-state logic: one query outstanding, request -> issue -> wait -> respond.
  always_comb begin
    StateDN    = StateDP;
    RrPtrDN    = RrPtrDP;
    ServedIdDN = ServedIdDP;
    HvDN       = HvDP;
    ResDN      = ResDP;
`ifdef AM_ARB_TIMEOUT_EN
    TimerDN    = TimerDP;
    TimeoutDN  = TimeoutDP;
`endif
    case (StateDP)
      IDLE: begin
        if (grantHit) begin
          HvDN       = reqHv[grantId];
          ServedIdDN = grantId;
          StateDN    = ISSUE;
        end
      end
      ISSUE: begin
        if (AmReady_SI) begin
          StateDN = WAIT_RESULT;
`ifdef AM_ARB_TIMEOUT_EN
          TimerDN = '0;
`endif
        end
      end
      WAIT_RESULT: begin
        if (AmResValid_SI) begin
          ResDN.labelA = AmLabel_A_DI;
          ResDN.labelV = AmLabel_V_DI;
          ResDN.distA  = AmDistance_A_DI;
          ResDN.distV  = AmDistance_V_DI;
          StateDN      = RESPOND;
`ifdef AM_ARB_TIMEOUT_EN
          TimeoutDN    = 1'b0;
        end else if (TimerDP == TimerLast) begin
          // Watchdog answer: no label, worst possible distance.
          ResDN.labelA = '0;
          ResDN.labelV = '0;
          ResDN.distA  = '1;
          ResDN.distV  = '1;
          TimeoutDN    = 1'b1;
          StateDN      = RESPOND;
        end else begin
          TimerDN = TimerDP + 8'd1;
`endif
        end
      end
      RESPOND: begin
        if (RespReady_SI[ServedIdDP]) begin
          StateDN = IDLE;
          RrPtrDN = (ServedIdDP == ID_W'(NUM_REQ - 1)) ? '0 : ServedIdDP + ID_W'(1);
        end
      end
      default: StateDN = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      StateDP    <= IDLE;
      RrPtrDP    <= '0;
      ServedIdDP <= '0;
      HvDP       <= '0;
      ResDP      <= '0;
    end else begin
      StateDP    <= StateDN;
      RrPtrDP    <= RrPtrDN;
      ServedIdDP <= ServedIdDN;
      HvDP       <= HvDN;
      ResDP      <= ResDN;
    end
  end

`ifdef AM_ARB_TIMEOUT_EN
  // Watchdog counter and timeout flag.
  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      TimerDP   <= '0;
      TimeoutDP <= 1'b0;
    end else begin
      TimerDP   <= TimerDN;
      TimeoutDP <= TimeoutDN;
    end
  end
  assign RespTimeout_SO = TimeoutDP;
`else
  assign RespTimeout_SO = 1'b0;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : gLane
    am_query_arbiter_lane #(
      .ID_W (ID_W),
      .CH   (g)
    ) iLane (
      .grantId   (grantId),
      .grantHit  (grantHit),
      .servedId  (ServedIdDP),
      .inIdle    (StateDP == IDLE),
      .inRespond (StateDP == RESPOND),
      .reqReady  (ReqReady_SO[g]),
      .respValid (RespValid_SO[g])
    );
  end

  assign AmValid_SO        = (StateDP == ISSUE);
  assign AmResReady_SO     = (StateDP == WAIT_RESULT);
  assign AmHypervector_DO  = HvDP;
  assign RespLabel_A_DO    = ResDP.labelA;
  assign RespLabel_V_DO    = ResDP.labelV;
  assign RespDistance_A_DO = ResDP.distA;
  assign RespDistance_V_DO = ResDP.distV;
  assign RespId_DO         = ServedIdDP;

endmodule

// File: tb/tb_am_query_arbiter.sv
// Directed bench for am_query_arbiter (NUM_REQ=3, TIMEOUT_CYCLES=10).
// Build with AM_ARB_TIMEOUT_EN to exercise the watchdog path.

`ifndef HV_DIMENSION
`define HV_DIMENSION 32
`endif
`ifndef LABEL_WIDTH
`define LABEL_WIDTH 4
`endif
`ifndef DISTANCE_WIDTH
`define DISTANCE_WIDTH 8
`endif

module tb_am_query_arbiter;
  localparam int N  = 3;
  localparam int HV = `HV_DIMENSION;
  localparam int LW = `LABEL_WIDTH;
  localparam int DW = `DISTANCE_WIDTH;

  logic                 Clk_CI = 1'b0;
  logic                 Reset_RBI;
  logic [N-1:0]         ReqValid_SI, ReqReady_SO, RespValid_SO, RespReady_SI;
  logic [N-1:0][HV-1:0] reqHv;
  logic                 AmValid_SO, AmReady_SI, AmResValid_SI, AmResReady_SO;
  logic [HV-1:0]        AmHypervector_DO;
  logic [LW-1:0]        AmLabel_A_DI, AmLabel_V_DI, RespLabel_A_DO, RespLabel_V_DO;
  logic [DW-1:0]        AmDistance_A_DI, AmDistance_V_DI, RespDistance_A_DO, RespDistance_V_DO;
  logic [1:0]           RespId_DO;
  logic                 RespTimeout_SO;

  int nTests = 0, nFail = 0;
  int amXfer = 0, respXfer = 0;

  always #5 Clk_CI = ~Clk_CI;

  am_query_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(10)) dut (
    .Clk_CI(Clk_CI), .Reset_RBI(Reset_RBI),
    .ReqValid_SI(ReqValid_SI), .ReqReady_SO(ReqReady_SO),
    .ReqHypervector_DI(reqHv),
    .AmValid_SO(AmValid_SO), .AmReady_SI(AmReady_SI),
    .AmHypervector_DO(AmHypervector_DO),
    .AmResValid_SI(AmResValid_SI), .AmResReady_SO(AmResReady_SO),
    .AmLabel_A_DI(AmLabel_A_DI), .AmLabel_V_DI(AmLabel_V_DI),
    .AmDistance_A_DI(AmDistance_A_DI), .AmDistance_V_DI(AmDistance_V_DI),
    .RespValid_SO(RespValid_SO), .RespReady_SI(RespReady_SI),
    .RespLabel_A_DO(RespLabel_A_DO), .RespLabel_V_DO(RespLabel_V_DO),
    .RespDistance_A_DO(RespDistance_A_DO), .RespDistance_V_DO(RespDistance_V_DO),
    .RespId_DO(RespId_DO), .RespTimeout_SO(RespTimeout_SO)
  );

  // Handshake counters on the memory query and response sides.
  always @(posedge Clk_CI) begin
    if (Reset_RBI) begin
      if (AmValid_SO && AmReady_SI) amXfer++;
      if (|(RespValid_SO & RespReady_SI)) respXfer++;
    end
  end

  task automatic chkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge Clk_CI);
    #2;
  endtask

  logic [N-1:0] expOh [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  int n, bad, a0, r0;

  initial begin
    Reset_RBI = 1'b0; ReqValid_SI = '0; reqHv = '0; RespReady_SI = '0;
    AmReady_SI = 1'b0; AmResValid_SI = 1'b0;
    AmLabel_A_DI = '0; AmLabel_V_DI = '0; AmDistance_A_DI = '0; AmDistance_V_DI = '0;
    repeat (2) cyc();
    #1;
    // Reset state
    chkVal("rst_amvalid", 64'(AmValid_SO), 0);
    chkVal("rst_amresrdy", 64'(AmResReady_SO), 0);
    chkVal("rst_respvalid", 64'(RespValid_SO), 0);
    chkVal("rst_hv", 64'(AmHypervector_DO), 0);
    chkVal("rst_resp", 64'({RespLabel_A_DO, RespLabel_V_DO, RespDistance_A_DO, RespDistance_V_DO}), 0);
    chkVal("rst_id", 64'(RespId_DO), 0);
    chkVal("rst_tmo", 64'(RespTimeout_SO), 0);
    cyc();
    Reset_RBI = 1'b1;

    // Single request on ch1, all partners ready
    cyc();
    AmReady_SI = 1'b1; AmResValid_SI = 1'b1; RespReady_SI = '1;
    reqHv[0] = 32'h0000_1111; reqHv[1] = 32'hA5A5_A5A5; reqHv[2] = 32'h5A5A_3C3C;
    AmLabel_A_DI = 4'h3; AmLabel_V_DI = 4'h5; AmDistance_A_DI = 8'h12; AmDistance_V_DI = 8'h34;
    ReqValid_SI = 3'b010;
    #1;
    chkVal("s_reqrdy", 64'(ReqReady_SO), 64'(3'b010));
    cyc(); ReqValid_SI = '0; #1;
    chkVal("s_amvalid", 64'(AmValid_SO), 1);
    chkVal("s_hv", 64'(AmHypervector_DO), 64'h0000_0000_A5A5_A5A5);
    cyc(); #1;
    chkVal("s_amresrdy", 64'(AmResReady_SO), 1);
    cyc(); #1;
    chkVal("s_respvalid", 64'(RespValid_SO), 64'(3'b010));
    chkVal("s_respid", 64'(RespId_DO), 1);
    chkVal("s_resp", 64'({RespLabel_A_DO, RespLabel_V_DO, RespDistance_A_DO, RespDistance_V_DO}),
           64'({4'h3, 4'h5, 8'h12, 8'h34}));
    cyc(); #1;
    chkVal("s_idle", 64'(RespValid_SO), 0);

    // Contention from reset: grants 0,1,2,0
    Reset_RBI = 1'b0; #1; Reset_RBI = 1'b1;
    ReqValid_SI = 3'b111;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (ReqReady_SO == '0 && n < 20) begin
        cyc(); #1; n++;
      end
      chkVal($sformatf("c_grant%0d", k), 64'(ReqReady_SO), 64'(expOh[k]));
      cyc(); #1;
      if (k == 0) chkVal("c_midrdy", 64'(ReqReady_SO), 0);
    end
    ReqValid_SI = '0;
    repeat (5) cyc();

    // Backpressure: AmReady low 5 cycles, then RespReady low 3 cycles
    Reset_RBI = 1'b0; #1; Reset_RBI = 1'b1;
    AmReady_SI = 1'b0; AmResValid_SI = 1'b1; RespReady_SI = 3'b110;
    AmLabel_A_DI = 4'h9; AmLabel_V_DI = 4'h6; AmDistance_A_DI = 8'hAB; AmDistance_V_DI = 8'hCD;
    reqHv[0] = 32'hDEAD_BEEF;
    a0 = amXfer; r0 = respXfer;
    ReqValid_SI = 3'b001;
    #1;
    chkVal("b_reqrdy", 64'(ReqReady_SO), 64'(3'b001));
    cyc();
    ReqValid_SI = '0; reqHv[0] = '0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (!AmValid_SO || AmHypervector_DO != 32'hDEAD_BEEF) bad++;
      cyc();
    end
    AmReady_SI = 1'b1;
    #1;
    chkVal("b_hold_hv", 64'(bad), 0);
    chkVal("b_hv", 64'(AmHypervector_DO), 64'h0000_0000_DEAD_BEEF);
    cyc(); AmReady_SI = 1'b0; #1;
    chkVal("b_amresrdy", 64'(AmResReady_SO), 1);
    cyc();
    AmResValid_SI = 1'b0; AmLabel_A_DI = 4'h1; AmLabel_V_DI = 4'h2;
    AmDistance_A_DI = 8'h77; AmDistance_V_DI = 8'h88;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (RespValid_SO != 3'b001 ||
          {RespLabel_A_DO, RespLabel_V_DO, RespDistance_A_DO, RespDistance_V_DO} != {4'h9, 4'h6, 8'hAB, 8'hCD})
        bad++;
      cyc();
    end
    RespReady_SI = 3'b001;
    #1;
    chkVal("b_hold_resp", 64'(bad), 0);
    chkVal("b_respvalid", 64'(RespValid_SO), 64'(3'b001));
    cyc(); #1;
    chkVal("b_done", 64'(RespValid_SO), 0);
    chkVal("b_amxfer", 64'(amXfer - a0), 1);
    chkVal("b_respxfer", 64'(respXfer - r0), 1);
    chkVal("b_keepdata", 64'(RespDistance_A_DO), 64'(8'hAB));

    // Reset in WAIT_RESULT, late result pulse ignored
    RespReady_SI = '1; AmReady_SI = 1'b1; AmResValid_SI = 1'b0;
    ReqValid_SI = 3'b100;
    cyc(); ReqValid_SI = '0;
    cyc(); #1;
    chkVal("r_inwait", 64'(AmResReady_SO), 1);
    Reset_RBI = 1'b0; #1;
    chkVal("r_amresrdy", 64'(AmResReady_SO), 0);
    cyc(); Reset_RBI = 1'b1;
    cyc(); cyc(); AmResValid_SI = 1'b1;
    cyc(); AmResValid_SI = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (RespValid_SO != '0 || AmResReady_SO || AmValid_SO) bad++;
      cyc();
    end
    chkVal("r_ignored", 64'(bad), 0);
    chkVal("r_resp", 64'({RespLabel_A_DO, RespDistance_A_DO}), 0);

    // Watchdog behaviour
    AmResValid_SI = 1'b0; AmReady_SI = 1'b1; RespReady_SI = '0;
    ReqValid_SI = 3'b001;
    cyc(); ReqValid_SI = '0;
    cyc(); #1;
    chkVal("t_inwait", 64'(AmResReady_SO), 1);
`ifdef AM_ARB_TIMEOUT_EN
    n = 0;
    while (RespValid_SO == '0 && n < 50) begin
      cyc(); #1; n++;
    end
    chkVal("t_latency", 64'(n), 10);
    chkVal("t_flag", 64'(RespTimeout_SO), 1);
    chkVal("t_dist", 64'({RespDistance_A_DO, RespDistance_V_DO}), 64'(16'hFFFF));
    chkVal("t_label", 64'({RespLabel_A_DO, RespLabel_V_DO}), 0);
`else
    repeat (1000) cyc();
    #1;
    chkVal("t_nowait_resp", 64'(RespValid_SO), 0);
    chkVal("t_stillwait", 64'(AmResReady_SO), 1);
    chkVal("t_noflag", 64'(RespTimeout_SO), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
